// File: rtl/result_collector.sv
// result_collector: reorder buffer that accepts tagged adder results out of order and
// presents them strictly in slot-index order. Optional result_count via RESULT_COLLECTOR_STATS_EN.
`default_nettype none

module result_collector #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  done_in,
  input  logic [31:0]           sum_in,
  input  logic [31:0]           z_in,
  input  logic [3:0]            opcode_in,
  input  logic [7:0]            tag_in,
  input  logic                  flush,
  input  logic                  result_ready,
  output logic                  result_valid,
  output logic [31:0]           result_sum,
  output logic [31:0]           result_z,
  output logic [3:0]            result_opcode,
  output logic [7:0]            result_tag,
  output logic                  collision,
  output logic [DEPTH_LOG2:0]   occupancy
`ifdef RESULT_COLLECTOR_STATS_EN
  ,
  output logic [15:0]           result_count
`endif
);

  localparam int c_depth = 1 << DEPTH_LOG2;

  logic [c_depth-1:0]    r_slot_vld;
  logic [31:0]           r_slot_sum [c_depth];
  logic [31:0]           r_slot_z   [c_depth];
  logic [3:0]            r_slot_op  [c_depth];
  logic [7:0]            r_slot_tag [c_depth];
  logic [DEPTH_LOG2-1:0] r_next_idx;
  logic [DEPTH_LOG2:0]   r_occ;
  logic                  r_collision;
  logic                  r_valid;
  logic [31:0]           r_res_sum;
  logic [31:0]           r_res_z;
  logic [3:0]            r_res_op;
  logic [7:0]            r_res_tag;

  logic [DEPTH_LOG2-1:0] w_wr_idx;
  logic                  w_slot_busy;
  logic                  w_store;
  logic                  w_collide;
  logic                  w_release;
  logic                  w_drop;
  logic [c_depth-1:0]    w_vld_next;
  logic [DEPTH_LOG2:0]   w_occ_next;

  assign w_wr_idx    = tag_in[DEPTH_LOG2-1:0];
  // A slot being released this edge still reads as busy, so a write to it collides.
  assign w_slot_busy = r_slot_vld[w_wr_idx];
  assign w_store     = done_in & ~w_slot_busy & ~flush;
  assign w_collide   = done_in &  w_slot_busy & ~flush;
  assign w_release   = r_slot_vld[r_next_idx] & (~r_valid | result_ready) & ~flush;
  assign w_drop      = r_valid & result_ready & ~w_release;

  always_comb begin
    w_vld_next = r_slot_vld;
    if (w_release) w_vld_next[r_next_idx] = 1'b0;
    if (w_store)   w_vld_next[w_wr_idx]   = 1'b1;
  end

  always_comb begin
    w_occ_next = r_occ;
    if (w_store && !w_release)      w_occ_next = r_occ + 1'b1;
    else if (!w_store && w_release) w_occ_next = r_occ - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (w_store) begin
      r_slot_sum[w_wr_idx] <= sum_in;
      r_slot_z[w_wr_idx]   <= z_in;
      r_slot_op[w_wr_idx]  <= opcode_in;
      r_slot_tag[w_wr_idx] <= tag_in;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_slot_vld  <= '0;
      r_next_idx  <= '0;
      r_occ       <= '0;
      r_collision <= 1'b0;
      r_valid     <= 1'b0;
      r_res_sum   <= '0;
      r_res_z     <= '0;
      r_res_op    <= '0;
      r_res_tag   <= '0;
    end else begin
      if (w_collide) r_collision <= 1'b1;
      if (flush) begin
        r_slot_vld <= '0;
        r_next_idx <= '0;
        r_occ      <= '0;
        r_valid    <= 1'b0;
      end else begin
        r_slot_vld <= w_vld_next;
        r_occ      <= w_occ_next;
        if (w_release) begin
          r_next_idx <= r_next_idx + 1'b1;
          r_valid    <= 1'b1;
          r_res_sum  <= r_slot_sum[r_next_idx];
          r_res_z    <= r_slot_z[r_next_idx];
          r_res_op   <= r_slot_op[r_next_idx];
          r_res_tag  <= r_slot_tag[r_next_idx];
        end else if (w_drop) begin
          r_valid <= 1'b0;
        end
      end
    end
  end

`ifdef RESULT_COLLECTOR_STATS_EN
  logic [15:0] r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                     r_count <= '0;
    else if (r_valid && result_ready) r_count <= r_count + 16'd1;
  end

  assign result_count = r_count;
`endif

  assign result_valid  = r_valid;
  assign result_sum    = r_res_sum;
  assign result_z      = r_res_z;
  assign result_opcode = r_res_op;
  assign result_tag    = r_res_tag;
  assign collision     = r_collision;
  assign occupancy     = r_occ;

endmodule

`default_nettype wire

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector: expected results queued on drive, popped on output.
`default_nettype none

module tb_result_collector;

  typedef struct packed {
    logic [31:0] s;
    logic [31:0] z;
    logic [3:0]  op;
    logic [7:0]  tag;
  } res_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        done_in = 1'b0;
  logic [31:0] sum_in = '0;
  logic [31:0] z_in = '0;
  logic [3:0]  opcode_in = '0;
  logic [7:0]  tag_in = '0;
  logic        flush = 1'b0;
  logic        result_ready = 1'b0;
  logic        result_valid;
  logic [31:0] result_sum;
  logic [31:0] result_z;
  logic [3:0]  result_opcode;
  logic [7:0]  result_tag;
  logic        collision;
  logic [4:0]  occupancy;
`ifdef RESULT_COLLECTOR_STATS_EN
  logic [15:0] result_count;
`endif

  res_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] in_order_sums [3] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};

  result_collector #(.DEPTH_LOG2(4)) dut (
    .clock(clock), .reset_n(reset_n), .done_in(done_in), .sum_in(sum_in), .z_in(z_in),
    .opcode_in(opcode_in), .tag_in(tag_in), .flush(flush), .result_ready(result_ready),
    .result_valid(result_valid), .result_sum(result_sum), .result_z(result_z),
    .result_opcode(result_opcode), .result_tag(result_tag), .collision(collision),
    .occupancy(occupancy)
`ifdef RESULT_COLLECTOR_STATS_EN
    , .result_count(result_count)
`endif
  );

  always #5 clock = ~clock;

  function automatic res_t mk(input logic [7:0] tag, input logic [31:0] s);
    res_t r;
    r.s   = s;
    r.z   = s ^ 32'h5A5A_0F0F ^ {24'h0, tag};
    r.op  = tag[3:0] ^ 4'h9;
    r.tag = tag;
    return r;
  endfunction

  task automatic drive(input res_t r);
    done_in = 1'b1; sum_in = r.s; z_in = r.z; opcode_in = r.op; tag_in = r.tag;
  endtask

  task automatic do_flush();
    @(posedge clock); #1; done_in = 1'b0; flush = 1'b1;
    @(posedge clock); #1; flush = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if ({result_valid, result_sum, result_z, result_opcode, result_tag, collision, occupancy} !== '0) begin
      n_err++;
      $display("FAIL reset_state: valid=%b sum=%h z=%h op=%h tag=%h col=%b occ=%0d, expected all 0",
               result_valid, result_sum, result_z, result_opcode, result_tag, collision, occupancy);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_in_order();
    int hits, first, last;
    res_t r, e, got;
    hits = 0; first = -1; last = -1;
    exp_q.delete();
    result_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock); #1;
      if (c < 3) begin r = mk(8'(c), in_order_sums[c]); drive(r); exp_q.push_back(r); end
      else done_in = 1'b0;
      @(negedge clock);
      if (result_valid) begin
        hits++; if (first < 0) first = c; last = c;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL in_order_extra: tag=%h, expected no result", result_tag);
        end else begin
          e = exp_q.pop_front();
          got = {result_sum, result_z, result_opcode, result_tag};
          if (got !== e) begin n_err++; $display("FAIL in_order_data: got %h, expected %h", got, e); end
        end
      end
    end
    n_cmp++;
    if (hits !== 3 || first !== 2 || last !== 4) begin
      n_err++; $display("FAIL in_order_timing: hits=%0d first=%0d last=%0d, expected 3/2/4", hits, first, last);
    end
    n_cmp++;
    if (occupancy !== 0 || exp_q.size() != 0) begin
      n_err++; $display("FAIL in_order_drain: occ=%0d left=%0d, expected 0/0", occupancy, exp_q.size());
    end
  endtask

  task automatic test_reorder();
    int hits, first, last;
    res_t e, got;
    hits = 0; first = -1; last = -1;
    do_flush();
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(8'(i), 32'h4100_0000 + i));
    result_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(posedge clock); #1;
      if (c < 3) drive(mk(8'(2 - c), 32'h4100_0000 + (2 - c)));
      else done_in = 1'b0;
      @(negedge clock);
      if (result_valid) begin
        hits++; if (first < 0) first = c; last = c;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL reorder_extra: tag=%h, expected no result", result_tag);
        end else begin
          e = exp_q.pop_front();
          got = {result_sum, result_z, result_opcode, result_tag};
          if (got !== e) begin n_err++; $display("FAIL reorder_data: got %h, expected %h", got, e); end
        end
      end
    end
    n_cmp++;
    if (hits !== 3 || first !== 4 || last !== 6) begin
      n_err++; $display("FAIL reorder_timing: hits=%0d first=%0d last=%0d, expected 3/4/6", hits, first, last);
    end
  endtask

  task automatic test_backpressure();
    int hits;
    res_t e, got;
    hits = 0;
    do_flush();
    exp_q.delete();
    result_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      drive(mk(8'(c), 32'h4200_0000 + c));
      exp_q.push_back(mk(8'(c), 32'h4200_0000 + c));
    end
    @(posedge clock); #1; done_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      got = {result_sum, result_z, result_opcode, result_tag};
      n_cmp++;
      if (!result_valid || got !== exp_q[0] || occupancy !== 2) begin
        n_err++;
        $display("FAIL backpressure_hold: valid=%b got=%h occ=%0d, expected 1/%h/2", result_valid, got, occupancy, exp_q[0]);
      end
    end
    @(posedge clock); #1; result_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (result_valid && result_ready) begin
        hits++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL backpressure_extra: tag=%h, expected no result", result_tag);
        end else begin
          e = exp_q.pop_front();
          got = {result_sum, result_z, result_opcode, result_tag};
          if (got !== e) begin n_err++; $display("FAIL backpressure_data: got %h, expected %h", got, e); end
        end
      end
    end
    n_cmp++;
    if (hits !== 3 || occupancy !== 0) begin
      n_err++; $display("FAIL backpressure_drain: hits=%0d occ=%0d, expected 3/0", hits, occupancy);
    end
  endtask

  task automatic test_collision_wrap();
    int hits;
    res_t e, got;
    logic [7:0] tags [5] = '{8'h03, 8'h13, 8'h00, 8'h01, 8'h02};
    do_flush();
    exp_q.delete();
    result_ready = 1'b1;
    n_cmp++;
    if (collision !== 1'b0) begin n_err++; $display("FAIL collision_clear: got %b, expected 0", collision); end
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(8'(i), 32'h4300_0000 + i));
    hits = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clock); #1;
      if (c < 5) drive(mk(tags[c], 32'h4300_0000 + {24'h0, tags[c]}));
      else done_in = 1'b0;
      @(negedge clock);
      if (c == 2) begin
        n_cmp++;
        if (collision !== 1'b1) begin n_err++; $display("FAIL collision_set: got %b, expected 1", collision); end
      end
      if (result_valid) begin
        hits++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL collision_extra: tag=%h, expected no result", result_tag);
        end else begin
          e = exp_q.pop_front();
          got = {result_sum, result_z, result_opcode, result_tag};
          if (got !== e) begin n_err++; $display("FAIL collision_data: got %h, expected %h", got, e); end
        end
      end
    end
    n_cmp++;
    if (hits !== 4) begin n_err++; $display("FAIL collision_count: got %0d results, expected 4", hits); end
    hits = 0;
    for (int c = 0; c < 26; c++) begin
      @(posedge clock); #1;
      if (c < 20) begin
        drive(mk(8'(4 + c), 32'h4400_0000 + c));
        exp_q.push_back(mk(8'(4 + c), 32'h4400_0000 + c));
      end else done_in = 1'b0;
      @(negedge clock);
      if (result_valid) begin
        hits++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL wrap_extra: tag=%h, expected no result", result_tag);
        end else begin
          e = exp_q.pop_front();
          got = {result_sum, result_z, result_opcode, result_tag};
          if (got !== e) begin n_err++; $display("FAIL wrap_data: got %h, expected %h", got, e); end
        end
      end
    end
    n_cmp++;
    if (hits !== 20 || occupancy !== 0 || collision !== 1'b1) begin
      n_err++; $display("FAIL wrap_drain: hits=%0d occ=%0d col=%b, expected 20/0/1", hits, occupancy, collision);
    end
  endtask

  task automatic test_flush();
    int hits;
    res_t e, got;
    do_flush();
    exp_q.delete();
    result_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      drive(mk(8'(c), 32'h4500_0000 + c));
    end
    @(posedge clock); #1; done_in = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (!result_valid || result_tag !== 8'h00 || occupancy !== 3) begin
      n_err++; $display("FAIL flush_fill: valid=%b tag=%h occ=%0d, expected 1/00/3", result_valid, result_tag, occupancy);
    end
    @(posedge clock); #1; flush = 1'b1;
    @(posedge clock); #1; flush = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (result_valid !== 1'b0 || occupancy !== 0 || collision !== 1'b1) begin
      n_err++; $display("FAIL flush_clear: valid=%b occ=%0d col=%b, expected 0/0/1", result_valid, occupancy, collision);
    end
    result_ready = 1'b1;
    hits = 0;
    exp_q.push_back(mk(8'h00, 32'h4600_0000));
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      if (c == 0) drive(mk(8'h00, 32'h4600_0000));
      else done_in = 1'b0;
      @(negedge clock);
      if (result_valid) begin
        hits++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL flush_extra: tag=%h, expected no result", result_tag);
        end else begin
          e = exp_q.pop_front();
          got = {result_sum, result_z, result_opcode, result_tag};
          if (got !== e) begin n_err++; $display("FAIL flush_data: got %h, expected %h", got, e); end
        end
      end
    end
    n_cmp++;
    if (hits !== 1) begin n_err++; $display("FAIL flush_release: got %0d results, expected 1", hits); end
  endtask

  task automatic test_reset_mid();
    int hits;
    res_t e, got;
    exp_q.delete();
    result_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      drive(mk(8'(c), 32'h4700_0000 + c));
    end
    #1;
    n_cmp++;
    if (result_valid !== 1'b1) begin n_err++; $display("FAIL reset_mid_busy: valid=%b, expected 1", result_valid); end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({result_valid, result_sum, result_z, result_opcode, result_tag, collision, occupancy} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_async: valid=%b sum=%h tag=%h col=%b occ=%0d, expected all 0",
               result_valid, result_sum, result_tag, collision, occupancy);
    end
    done_in = 1'b0;
    @(posedge clock); #1; reset_n = 1'b1;
    hits = 0;
    exp_q.push_back(mk(8'h00, 32'h4800_0000));
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      if (c == 0) drive(mk(8'h00, 32'h4800_0000));
      else done_in = 1'b0;
      @(negedge clock);
      if (result_valid) begin
        hits++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL reset_mid_extra: tag=%h, expected no result", result_tag);
        end else begin
          e = exp_q.pop_front();
          got = {result_sum, result_z, result_opcode, result_tag};
          if (got !== e) begin n_err++; $display("FAIL reset_mid_data: got %h, expected %h", got, e); end
        end
      end
    end
    n_cmp++;
    if (hits !== 1 || occupancy !== 0) begin
      n_err++; $display("FAIL reset_mid_release: hits=%0d occ=%0d, expected 1/0", hits, occupancy);
    end
  endtask

`ifdef RESULT_COLLECTOR_STATS_EN
  task automatic test_stats();
    test_reset();
    n_cmp++;
    if (result_count !== 16'd0) begin n_err++; $display("FAIL stats_reset: got %0d, expected 0", result_count); end
    result_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock); #1;
      if (c < 3) drive(mk(8'(c), 32'h4900_0000 + c));
      else done_in = 1'b0;
    end
    @(negedge clock);
    n_cmp++;
    if (result_count !== 16'd3) begin n_err++; $display("FAIL stats_count: got %0d, expected 3", result_count); end
    do_flush();
    @(negedge clock);
    n_cmp++;
    if (result_count !== 16'd3) begin n_err++; $display("FAIL stats_flush: got %0d, expected 3", result_count); end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (result_count !== 16'd0) begin n_err++; $display("FAIL stats_clear: got %0d, expected 0", result_count); end
    @(posedge clock); #1; reset_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_in_order();
    test_reorder();
    test_backpressure();
    test_collision_wrap();
    test_flush();
    test_reset_mid();
`ifdef RESULT_COLLECTOR_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 Parameter: DEPTH_LOG2, 4, log2 of reorder slots; legal 2..8; slot index = tag_in[DEPTH_LOG2-1:0].
REQ-002 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: done_in  input  1  result strobe from the adder pipeline's Done; one result per high cycle.
REQ-005 Port: sum_in  input  32  IEEE-754 single result (FinalSum).
REQ-006 Port: z_in  input  32  z passthrough (z_postprocess).
REQ-007 Port: opcode_in  input  4  opcode passthrough.
REQ-008 Port: tag_in  input  8  instruction tag.
REQ-009 Port: flush  input  1  synchronous discard of all buffered and presented results.
REQ-010 Port: result_ready  input  1  downstream accept.
REQ-011 Port: result_valid  output  1  presented result valid.
REQ-012 Port: result_sum / result_z  output  32 each  presented sum and z.
REQ-013 Port: result_opcode  output  4  presented opcode.
REQ-014 Port: result_tag  output  8  full 8-bit tag of presented result.
REQ-015 Port: collision  output  1  sticky error, write to an occupied slot.
REQ-016 Port: occupancy  output  DEPTH_LOG2+1  count of occupied slots, excluding the output register.

Function
REQ-017 Each slot SHALL hold sum, z, opcode, 8-bit tag and a valid bit; all outputs registered.
REQ-018 On done_in=1 with slot tag_in[DEPTH_LOG2-1:0] empty, the block SHALL store the fields and set the slot valid at that edge.
REQ-019 On done_in=1 with slot already valid, the write SHALL be dropped and collision set at that edge, held until reset.
REQ-020 Release pointer next_idx SHALL start at 0 and increment modulo 2^DEPTH_LOG2 on each release.
REQ-021 Release SHALL occur at an edge where slot[next_idx] is valid and (result_valid=0 or result_ready=1): output register loads slot contents, slot valid clears, result_valid=1.
REQ-022 When result_valid=1, result_ready=1 and no release occurs, result_valid SHALL go 0.
REQ-023 While result_valid=1 and result_ready=0, all result_* outputs SHALL hold stable.
REQ-024 Latency: result stored at edge E SHALL be presentable at edge E+1 at earliest; sustained throughput one result per cycle when ready is held high and slots fill in order.
REQ-025 A write to slot next_idx at the same edge that slot is released SHALL count as a collision (slot read as valid that cycle); the released data SHALL be the old contents.
REQ-026 Out-of-order arrivals SHALL be held until all lower-sequence slots release; results SHALL leave strictly in slot-index order with wrap-around.
REQ-027 occupancy SHALL equal stored minus released slots, with simultaneous store and release leaving it unchanged; maximum 2^DEPTH_LOG2.
REQ-028 flush=1 SHALL clear all slot valids, result_valid and occupancy and set next_idx=0 at the edge, with priority over done_in and release; collision unaffected.

Reset
REQ-029 reset_n=0 SHALL immediately clear slot valids, next_idx, result_valid, collision, occupancy and the stats counter; result_sum, result_z, result_opcode and result_tag SHALL reset to 0.
REQ-030 Reset asserted mid-transfer SHALL discard all buffered results; after deassertion the first release expects slot 0.

Configuration
REQ-031 With RESULT_COLLECTOR_STATS_EN defined, the block SHALL add output result_count (16 bits), incremented on each accepted transfer (result_valid and result_ready both 1), wrapping 0xFFFF->0, cleared by reset but not by flush.
REQ-032 Without RESULT_COLLECTOR_STATS_EN, the result_count port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-033 In order: tags 0x00,0x01,0x02 on consecutive cycles with sums 0x3F800000,0x40000000,0x40400000, ready=1 -> three consecutive result_valid cycles in that order, occupancy returns to 0.
REQ-034 Reorder: tag 0x02 then 0x01 then 0x00 -> no result_valid until tag 0x00 stored, then tags 0x00,0x01,0x02 out on three consecutive cycles.
REQ-035 Backpressure: ready=0 for 5 cycles with tag 0x00 presented -> outputs stable, occupancy counts further stores; ready=1 -> drain in order.
REQ-036 Collision and wrap: tag 0x03 stored, then tag 0x13 before release -> collision=1, second write dropped, result_tag=0x03; run 20 in-order tags -> next_idx wraps 15->0 with no loss.
REQ-037 Flush and reset: 4 slots filled, flush=1 -> result_valid=0 and occupancy=0 next cycle; then tag 0x00 -> released. reset_n low mid-drain -> outputs 0 immediately.
REQ-038 With RESULT_COLLECTOR_STATS_EN: 3 accepted transfers -> result_count=3; flush leaves 3; reset clears it to 0.
